minkowski_net_14_layer_pipeline_mac_accum: RTL and testbench
============================================================

MINKOWSKI_NET_14_LAYER_PIPELINE_MAC_ACCUM -- requirements
Module: minkowski_net_14_layer_pipeline_mac_accum

Interface
REQ-001 Parameter IN_WIDTH, default 22: width of the unsigned product stream from the upstream 11x11 multiplier.
REQ-002 Parameter ACC_WIDTH, default 32: accumulator width, unsigned.
REQ-003 Parameter OUT_WIDTH, default 16: requantized result width, unsigned.
REQ-004 Parameter SHIFT, default 8: requantization right-shift, valid range 1..ACC_WIDTH-1.
REQ-005 Parameter MAX_TAPS, default 27: maximum products per kernel window (3x3x3).
REQ-006 ap_clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 in_data  input  IN_WIDTH  product beat, unsigned.
REQ-009 in_last  input  1  marks the final product of the current window.
REQ-010 in_valid  input  1  upstream beat present.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 out_data  output  OUT_WIDTH  rounded, saturated window sum.
REQ-013 out_taps  output  5  number of beats accumulated in the emitted window (1..MAX_TAPS).
REQ-014 out_sat  output  1  the accumulator or output saturated in the emitted window.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  downstream accepts result.

Function
REQ-017 The block SHALL implement three states: IDLE (no beats in window), ACCUM (at least one beat accumulated), HOLD (result registered, awaiting out_ready).
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both high; in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-019 On an accepted beat, acc SHALL become acc + in_data (acc = 0 implied in IDLE), computed at ACC_WIDTH+1 bits and clamped to 2^ACC_WIDTH-1; a clamp SHALL set the window's sticky sat flag.
REQ-020 The tap counter SHALL increment per accepted beat; a beat with in_last=1, or the beat taking the count to MAX_TAPS, SHALL close the window.
REQ-021 Transitions: IDLE->ACCUM on an accepted non-closing beat; IDLE or ACCUM->HOLD on a closing beat; ACCUM holds otherwise; HOLD->IDLE when out_ready=1.
REQ-022 On window close, out_data SHALL be min((acc_final + 2^(SHIFT-1)) >> SHIFT, 2^OUT_WIDTH-1), with the add performed at ACC_WIDTH+1 bits, and an output clamp SHALL also set out_sat.
REQ-023 out_valid SHALL rise the cycle after the closing beat is accepted (latency 1) and remain high, with out_data/out_taps/out_sat stable, until out_valid and out_ready are both high.
REQ-024 A new beat SHALL NOT be accepted in the cycle the result handshakes; the first beat of the next window is accepted no earlier than the following cycle (one bubble per window).
REQ-025 Accumulator, tap counter and sat flag SHALL clear on entry to IDLE.
REQ-026 in_last asserted while in_valid=0 SHALL be ignored.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 Asserting ap_rst_n=0 SHALL immediately, independent of ap_clk, force state IDLE, acc=0, taps=0, sat=0, out_valid=0, out_data=0, out_taps=0, out_sat=0.
REQ-029 in_ready SHALL read 0 while ap_rst_n=0 and 1 from the first clock edge after deassertion.
REQ-030 Reset mid-window or in HOLD SHALL discard the partial or pending result without emitting it.

Verification
REQ-031 Beats 100, 200, 300 (last on 300) -> one cycle later out_valid=1, out_data=2, out_taps=3, out_sat=0.
REQ-032 Single beat 4190209 (2047*2047) with in_last=1 -> out_data=16368, out_taps=1, out_sat=0.
REQ-033 27 beats of 4190209, in_last never set -> window closes on the 27th beat, out_data=65535, out_taps=27, out_sat=1; the 28th beat starts a new window.
REQ-034 ACC_WIDTH=24 override, 5 beats of 4190209, last on the 5th -> acc clamps at 16777215, out_data=65535, out_sat=1.
REQ-035 out_ready held low 5 cycles after result -> out_valid, out_data and out_taps stable, in_ready=0 throughout; the next beat is accepted the cycle after the handshake cycle.
REQ-036 ap_rst_n pulsed low after 2 of 3 beats -> no result emitted; a fresh beat 512 with in_last=1 -> out_data=2, out_taps=1.

Source files
------------

// File: rtl/minkowski_net_14_layer_pipeline_mac_accum_if.sv
// Product-beat input stream and requantized result stream of the window MAC.
// The master side is the producer/consumer environment; the slave side is the accumulator.
interface minkowski_net_14_layer_pipeline_mac_accum_if #(
    parameter int IN_WIDTH  = 22,
    parameter int OUT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [4:0]           out_taps;
    logic                 out_sat;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_taps, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_taps, out_sat, out_valid
    );
endinterface

// File: rtl/minkowski_net_14_layer_pipeline_mac_accum.sv
// Kernel-window MAC accumulator: sums up to MAX_TAPS unsigned products per window,
// then rounds, right-shifts and saturates the window sum into one result beat.
module minkowski_net_14_layer_pipeline_mac_accum #(
    parameter int IN_WIDTH  = 22,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8,
    parameter int MAX_TAPS  = 27
) (
    input logic ap_clk,
    input logic ap_rst_n,
    minkowski_net_14_layer_pipeline_mac_accum_if.slave s
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [ACC_WIDTH:0] OUT_MAX = (ACC_WIDTH+1)'((64'd1 << OUT_WIDTH) - 64'd1);
    localparam logic [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'(1) << (SHIFT - 1);

    // MSB of the result flags a clamp; lower bits carry the clamped sum.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [IN_WIDTH-1:0]  b);
        logic [ACC_WIDTH:0] sum;
        sum = {1'b0, a} + (ACC_WIDTH+1)'(b);
        if (sum[ACC_WIDTH]) sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
        else                sat_add = sum;
    endfunction

    function automatic logic [OUT_WIDTH:0] round_sat(input logic [ACC_WIDTH-1:0] a);
        logic [ACC_WIDTH:0] r;
        r = ({1'b0, a} + RND) >> SHIFT;
        if (r > OUT_MAX) round_sat = {1'b1, {OUT_WIDTH{1'b1}}};
        else             round_sat = {1'b0, r[OUT_WIDTH-1:0]};
    endfunction

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [4:0]             taps;
    logic                   sat;
    logic                   rdy_p0;
    logic                   vld_p0;
    logic [OUT_WIDTH-1:0]   data_p0;
    logic [4:0]             taps_p0;
    logic                   sat_p0;

    logic                   accept;
    logic                   close;
    logic [4:0]             taps_nx;
    logic                   sat_nx;
    logic [ACC_WIDTH:0]     sum_w;
    logic [OUT_WIDTH:0]     rnd_w;

    assign accept  = s.in_valid && rdy_p0;
    assign taps_nx = taps + 5'd1;
    assign close   = s.in_last || (taps_nx == 5'(MAX_TAPS));
    assign sum_w   = sat_add(acc, s.in_data);
    assign sat_nx  = sat | sum_w[ACC_WIDTH];
    assign rnd_w   = round_sat(sum_w[ACC_WIDTH-1:0]);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            taps    <= '0;
            sat     <= 1'b0;
            rdy_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            taps_p0 <= '0;
            sat_p0  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    rdy_p0 <= 1'b1;
                    if (accept) begin
                        acc  <= sum_w[ACC_WIDTH-1:0];
                        taps <= taps_nx;
                        sat  <= sat_nx;
                        if (close) begin
                            // Result registers load here; ready drops for the whole hold.
                            state   <= HOLD;
                            rdy_p0  <= 1'b0;
                            vld_p0  <= 1'b1;
                            data_p0 <= rnd_w[OUT_WIDTH-1:0];
                            taps_p0 <= taps_nx;
                            sat_p0  <= sat_nx | rnd_w[OUT_WIDTH];
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (s.out_ready) begin
                        // Ready rises only after the handshake cycle: one bubble per window.
                        state  <= IDLE;
                        vld_p0 <= 1'b0;
                        rdy_p0 <= 1'b1;
                        acc    <= '0;
                        taps   <= '0;
                        sat    <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rdy_p0 <= 1'b0;
                    vld_p0 <= 1'b0;
                end
            endcase
        end
    end

    assign s.in_ready  = rdy_p0;
    assign s.out_valid = vld_p0;
    assign s.out_data  = data_p0;
    assign s.out_taps  = taps_p0;
    assign s.out_sat   = sat_p0;
endmodule

// File: tb/tb_minkowski_net_14_layer_pipeline_mac_accum.sv
// Directed bench for the window MAC: table of windows plus hand-written corner sequences.
module tb_minkowski_net_14_layer_pipeline_mac_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    minkowski_net_14_layer_pipeline_mac_accum_if #(.IN_WIDTH(22), .OUT_WIDTH(16)) bus0 ();
    minkowski_net_14_layer_pipeline_mac_accum_if #(.IN_WIDTH(22), .OUT_WIDTH(16)) bus1 ();

    minkowski_net_14_layer_pipeline_mac_accum dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .s(bus0.slave)
    );

    minkowski_net_14_layer_pipeline_mac_accum #(.ACC_WIDTH(24)) dut1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .s(bus1.slave)
    );

    // The narrow-accumulator instance sees identical stimulus.
    assign bus1.in_data   = bus0.in_data;
    assign bus1.in_last   = bus0.in_last;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.out_ready = bus0.out_ready;

    typedef struct {
        int n;
        int base;
        int step;
        bit last;
        int exp_data;
        int exp_taps;
        bit exp_sat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [21:0] d, input logic l);
        int w;
        w = 0;
        bus0.in_valid = 1'b1;
        bus0.in_data  = d;
        bus0.in_last  = l;
        while (!bus0.in_ready && w < 100) begin
            step();
            w++;
        end
        chk("in_ready_wait", {31'd0, bus0.in_ready}, 32'd1);
        step();
        bus0.in_valid = 1'b0;
        bus0.in_last  = 1'b0;
    endtask

    task automatic chk_result(input string name, input int d, input int t, input bit sa);
        chk({name, "_valid"}, {31'd0, bus0.out_valid}, 32'd1);
        chk({name, "_data"},  {16'd0, bus0.out_data},  d);
        chk({name, "_taps"},  {27'd0, bus0.out_taps},  t);
        chk({name, "_sat"},   {31'd0, bus0.out_sat},   {31'd0, sa});
    endtask

    task automatic handshake();
        bus0.out_ready = 1'b1;
        step();
        bus0.out_ready = 1'b0;
        chk("valid_drop", {31'd0, bus0.out_valid}, 32'd0);
    endtask

    initial begin
        bus0.in_data   = '0;
        bus0.in_last   = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b0;

        vecs[0] = '{3,  100,     100, 1'b1, 2,     3,  1'b0};
        vecs[1] = '{1,  4190209, 0,   1'b1, 16368, 1,  1'b0};
        vecs[2] = '{27, 4190209, 0,   1'b0, 65535, 27, 1'b1};
        vecs[3] = '{1,  512,     0,   1'b1, 2,     1,  1'b0};
        vecs[4] = '{1,  127,     0,   1'b1, 0,     1,  1'b0};
        vecs[5] = '{1,  128,     0,   1'b1, 1,     1,  1'b0};
        vecs[6] = '{2,  383,     0,   1'b1, 3,     2,  1'b0};
        vecs[7] = '{26, 1000,    0,   1'b1, 102,   26, 1'b0};
        vecs[8] = '{27, 1,       0,   1'b0, 0,     27, 1'b0};
        vecs[9] = '{1,  4194303, 0,   1'b1, 16384, 1,  1'b0};

        // Reset state
        #2;
        chk("rst_in_ready",  {31'd0, bus0.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_out_data",  {16'd0, bus0.out_data},  32'd0);
        chk("rst_out_taps",  {27'd0, bus0.out_taps},  32'd0);
        #10;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);

        // Table-driven windows
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                send(22'(vecs[v].base + k * vecs[v].step), vecs[v].last && (k == vecs[v].n - 1));
            end
            chk_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_taps, vecs[v].exp_sat);
            handshake();
        end

        // Stalled result: outputs stable, no acceptance during hold
        send(22'd100, 1'b0);
        send(22'd200, 1'b0);
        send(22'd300, 1'b1);
        bus0.in_valid = 1'b1;
        bus0.in_data  = 22'd512;
        bus0.in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_result($sformatf("stall%0d", c), 2, 3, 1'b0);
            chk($sformatf("stall%0d_in_ready", c), {31'd0, bus0.in_ready}, 32'd0);
        end
        bus0.out_ready = 1'b1;
        step();
        bus0.out_ready = 1'b0;
        chk("after_hs_valid",    {31'd0, bus0.out_valid}, 32'd0);
        chk("after_hs_in_ready", {31'd0, bus0.in_ready},  32'd1);
        step();
        bus0.in_valid = 1'b0;
        bus0.in_last  = 1'b0;
        chk_result("post_stall", 2, 1, 1'b0);
        handshake();

        // in_last without in_valid, out_ready without out_valid
        bus0.out_ready = 1'b1;
        send(22'd256, 1'b0);
        bus0.in_last = 1'b1;
        step();
        step();
        bus0.in_last = 1'b0;
        chk("ignored_last_valid", {31'd0, bus0.out_valid}, 32'd0);
        bus0.out_ready = 1'b0;
        send(22'd256, 1'b1);
        chk_result("ignored_last", 2, 2, 1'b0);
        handshake();

        // 28th beat opens a fresh window after the tap-limit close
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 27; k++) send(22'd4190209, 1'b0);
        chk_result("tap_limit", 65535, 27, 1'b1);
        send(22'd1024, 1'b1);
        chk_result("beat28", 4, 1, 1'b0);
        step();
        bus0.out_ready = 1'b0;
        chk("beat28_drop", {31'd0, bus0.out_valid}, 32'd0);

        // Narrow accumulator: 4 beats fit, 5 beats clamp
        for (int k = 0; k < 4; k++) send(22'd4190209, k == 3);
        chk("acc24_4_data", {16'd0, bus1.out_data}, 32'd65472);
        chk("acc24_4_sat",  {31'd0, bus1.out_sat},  32'd0);
        handshake();
        for (int k = 0; k < 5; k++) send(22'd4190209, k == 4);
        chk("acc24_5_valid", {31'd0, bus1.out_valid}, 32'd1);
        chk("acc24_5_data",  {16'd0, bus1.out_data},  32'd65535);
        chk("acc24_5_taps",  {27'd0, bus1.out_taps},  32'd5);
        chk("acc24_5_sat",   {31'd0, bus1.out_sat},   32'd1);
        chk_result("acc32_5", 65535, 5, 1'b1);
        handshake();

        // Reset mid-window discards the partial sum
        send(22'd100, 1'b0);
        send(22'd200, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  {31'd0, bus0.in_ready},  32'd0);
        chk("midrst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("midrst_rel_ready", {31'd0, bus0.in_ready}, 32'd1);
        send(22'd512, 1'b1);
        chk_result("midrst_fresh", 2, 1, 1'b0);

        // Reset while holding a result drops it immediately
        rst_n = 1'b0;
        #1;
        chk("holdrst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("holdrst_out_data",  {16'd0, bus0.out_data},  32'd0);
        chk("holdrst_out_taps",  {27'd0, bus0.out_taps},  32'd0);
        chk("holdrst_out_sat",   {31'd0, bus0.out_sat},   32'd0);
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk("holdrst_after", {31'd0, bus0.out_valid}, 32'd0);
        send(22'd300, 1'b1);
        chk_result("holdrst_fresh", 1, 1, 1'b0);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
